// File: rtl/pixfetch_pkg.sv
// Shared types and default sizes for the pixel fetch sequencer.
package pixfetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } pf_state_t;

  localparam int PIX_WIDTH = 24;
  localparam int PIX_DEPTH = 24;
  localparam int PIX_LANES = 4;

endpackage

// File: rtl/lane_pack_buf.sv
// LANES x WIDTH pixel staging buffer with per-lane valid mask.
module lane_pack_buf #(
  parameter int WIDTH = 24,
  parameter int LANES = 4,
  parameter int LW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [LW-1:0]          wr_lane,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [LANES*WIDTH-1:0] data,
  output logic [LANES-1:0]       mask
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] word;
    logic             vld;

    // Clear wins over a write so a fresh vector never inherits stale lanes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word <= '0;
        vld  <= 1'b0;
      end else if (clear) begin
        word <= '0;
        vld  <= 1'b0;
      end else if (wr_en && (wr_lane == LW'(gi))) begin
        word <= wr_data;
        vld  <= 1'b1;
      end
    end

    assign data[gi*WIDTH +: WIDTH] = word;
    assign mask[gi]                = vld;
  end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Streams pixels from a combinational ROM and packs them into LANES-wide
// vectors delivered over a valid/ready handshake.
module pixel_fetch_ctrl
  import pixfetch_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int DEPTH = PIX_DEPTH,
  parameter int LANES = PIX_LANES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       base,
  input  logic [WIDTH-1:0]       count,
  output logic [WIDTH-1:0]       mem_addr,
  input  logic [WIDTH-1:0]       mem_rd,
  output logic [LANES*WIDTH-1:0] vec_data,
  output logic [LANES-1:0]       vec_mask,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [WIDTH-1:0] DEPTH_W   = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 1);
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

  pf_state_t        state;
  logic [WIDTH-1:0] remaining;
  logic [LW-1:0]    lane;
  logic             buf_clear;
  logic             buf_wr;

  assign buf_wr    = (state == FETCH);
  assign buf_clear = ((state == IDLE) && start) ||
                     ((state == EMIT) && vec_ready && (remaining != '0));

  lane_pack_buf #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .LW    (LW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (buf_clear),
    .wr_en   (buf_wr),
    .wr_lane (lane),
    .wr_data (mem_rd),
    .data    (vec_data),
    .mask    (vec_mask)
  );

  // mem_addr doubles as the fetch pointer, so it stays frozen outside FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      lane      <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= base;
            remaining <= count;
            lane      <= '0;
            busy      <= 1'b1;
            if (base >= DEPTH_W) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          mem_addr  <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + WIDTH'(1);
          remaining <= remaining - WIDTH'(1);
          lane      <= lane + LW'(1);
          if ((lane == LAST_LANE) || (remaining == WIDTH'(1))) begin
            state     <= EMIT;
            vec_valid <= 1'b1;
            lane      <= '0;
          end
        end
        EMIT: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            if (remaining == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Directed bench for pixel_fetch_ctrl with ROM model mem[i] = i*24'h010101.
module tb_pixel_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] base;
  logic [23:0] count;
  logic [23:0] mem_addr;
  logic [23:0] mem_rd;
  logic [95:0] vec_data;
  logic [3:0]  vec_mask;
  logic        vec_valid;
  logic        vec_ready;
  logic        busy;
  logic        done;
  logic        err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  always_comb mem_rd = 24'(mem_addr * 24'h010101);

  pixel_fetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .vec_data  (vec_data),
    .vec_mask  (vec_mask),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start for cycle 0; returns at the sampling point of cycle 1.
  task automatic start_req(input logic [23:0] b, input logic [23:0] c);
    start = 1'b1;
    base  = b;
    count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_addr"},  96'(mem_addr), 96'h0);
    chk({tag, "_data"},  vec_data, 96'h0);
    chk({tag, "_mask"},  96'(vec_mask), 96'h0);
    chk({tag, "_valid"}, 96'(vec_valid), 96'h0);
    chk({tag, "_busy"},  96'(busy), 96'h0);
    chk({tag, "_done"},  96'(done), 96'h0);
    chk({tag, "_err"},   96'(err), 96'h0);
  endtask

  logic [95:0] v_a;
  logic [95:0] v_b;
  logic [95:0] v_c;
  logic [23:0] frozen_addr;

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; count = '0; vec_ready = 1'b0;
    tick(); tick();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: base=0 count=4, one full vector
    vec_ready = 1'b1;
    v_a = {24'h030303, 24'h020202, 24'h010101, 24'h000000};
    start_req(24'd0, 24'd4);
    chk("t1_busy", 96'(busy), 96'h1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t1_addr_c%0d", i), 96'(mem_addr), 96'(i - 1));
      chk($sformatf("t1_novalid_c%0d", i), 96'(vec_valid), 96'h0);
      tick();
    end
    $display("[TB] t1 vector data=%h mask=%h valid=%b", vec_data, vec_mask, vec_valid);
    chk("t1_valid_c5", 96'(vec_valid), 96'h1);
    chk("t1_data", vec_data, v_a);
    chk("t1_mask", 96'(vec_mask), 96'hF);
    tick();
    chk("t1_done_c6", 96'(done), 96'h1);
    chk("t1_err_c6", 96'(err), 96'h0);
    chk("t1_valid_c6", 96'(vec_valid), 96'h0);
    tick();
    chk("t1_done_c7", 96'(done), 96'h0);
    chk("t1_busy_c7", 96'(busy), 96'h0);

    // 2: base=22 count=5, address wrap and partial second vector
    v_a = {24'h010101, 24'h000000, 24'h171717, 24'h161616};
    v_b = {24'h000000, 24'h000000, 24'h000000, 24'h020202};
    start_req(24'd22, 24'd5);
    chk("t2_addr_c1", 96'(mem_addr), 96'd22);
    tick();
    chk("t2_addr_c2", 96'(mem_addr), 96'd23);
    tick();
    chk("t2_addr_c3", 96'(mem_addr), 96'd0);
    tick();
    chk("t2_addr_c4", 96'(mem_addr), 96'd1);
    tick();
    $display("[TB] t2 vector1 data=%h mask=%h", vec_data, vec_mask);
    chk("t2_v1_valid", 96'(vec_valid), 96'h1);
    chk("t2_v1_data", vec_data, v_a);
    chk("t2_v1_mask", 96'(vec_mask), 96'hF);
    tick();
    chk("t2_addr_c6", 96'(mem_addr), 96'd2);
    chk("t2_valid_c6", 96'(vec_valid), 96'h0);
    tick();
    $display("[TB] t2 vector2 data=%h mask=%h", vec_data, vec_mask);
    chk("t2_v2_valid", 96'(vec_valid), 96'h1);
    chk("t2_v2_data", vec_data, v_b);
    chk("t2_v2_mask", 96'(vec_mask), 96'h1);
    tick();
    chk("t2_done", 96'(done), 96'h1);
    chk("t2_err", 96'(err), 96'h0);
    tick();

    // 3: count=6 with a 10-cycle stall in the first EMIT
    vec_ready = 1'b0;
    v_a = {24'h030303, 24'h020202, 24'h010101, 24'h000000};
    v_c = {24'h000000, 24'h000000, 24'h050505, 24'h040404};
    start_req(24'd0, 24'd6);
    tick(); tick(); tick(); tick();
    frozen_addr = mem_addr;
    chk("t3_frozen_addr", 96'(frozen_addr), 96'd4);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_stall_valid_%0d", i), 96'(vec_valid), 96'h1);
      chk($sformatf("t3_stall_data_%0d", i), vec_data, v_a);
      chk($sformatf("t3_stall_addr_%0d", i), 96'(mem_addr), 96'(frozen_addr));
      tick();
    end
    $display("[TB] t3 stalled vector data=%h mask=%h", vec_data, vec_mask);
    vec_ready = 1'b1;
    tick();
    chk("t3_addr_f1", 96'(mem_addr), 96'd4);
    tick();
    chk("t3_addr_f2", 96'(mem_addr), 96'd5);
    tick();
    $display("[TB] t3 vector2 data=%h mask=%h", vec_data, vec_mask);
    chk("t3_v2_valid", 96'(vec_valid), 96'h1);
    chk("t3_v2_data", vec_data, v_c);
    chk("t3_v2_mask", 96'(vec_mask), 96'h3);
    tick();
    chk("t3_done", 96'(done), 96'h1);
    tick();

    // 4: zero count and out-of-range base
    start_req(24'd3, 24'd0);
    $display("[TB] t4 count=0 done=%b err=%b valid=%b", done, err, vec_valid);
    chk("t4_zero_done", 96'(done), 96'h1);
    chk("t4_zero_err", 96'(err), 96'h0);
    chk("t4_zero_valid", 96'(vec_valid), 96'h0);
    tick();
    chk("t4_zero_done_off", 96'(done), 96'h0);
    start_req(24'd24, 24'd3);
    $display("[TB] t4 base=24 done=%b err=%b", done, err);
    chk("t4_rej_done", 96'(done), 96'h1);
    chk("t4_rej_err", 96'(err), 96'h1);
    chk("t4_rej_valid", 96'(vec_valid), 96'h0);
    tick();
    chk("t4_rej_err_off", 96'(err), 96'h0);
    chk("t4_rej_busy_off", 96'(busy), 96'h0);

    // 5: second start mid-FETCH must be ignored
    start_req(24'd0, 24'd4);
    chk("t5_addr_c1", 96'(mem_addr), 96'd0);
    tick();
    chk("t5_addr_c2", 96'(mem_addr), 96'd1);
    start = 1'b1; base = 24'd10; count = 24'd1;
    tick();
    start = 1'b0;
    chk("t5_addr_c3", 96'(mem_addr), 96'd2);
    tick();
    chk("t5_addr_c4", 96'(mem_addr), 96'd3);
    tick();
    $display("[TB] t5 vector data=%h mask=%h", vec_data, vec_mask);
    chk("t5_valid", 96'(vec_valid), 96'h1);
    chk("t5_data", vec_data, v_a);
    chk("t5_mask", 96'(vec_mask), 96'hF);
    tick();
    chk("t5_done", 96'(done), 96'h1);
    chk("t5_err", 96'(err), 96'h0);
    tick();
    chk("t5_idle", 96'(busy), 96'h0);

    // 6: reset in the middle of EMIT, then a fresh request
    vec_ready = 1'b0;
    start_req(24'd0, 24'd4);
    tick(); tick(); tick(); tick();
    chk("t6_in_emit", 96'(vec_valid), 96'h1);
    rst_n = 1'b0;
    #1;
    $display("[TB] t6 async reset valid=%b busy=%b addr=%h", vec_valid, busy, mem_addr);
    chk_idle_zero("t6_rst");
    tick();
    chk("t6_no_done_a", 96'(done), 96'h0);
    tick();
    chk("t6_no_done_b", 96'(done), 96'h0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_done_c", 96'(done), 96'h0);
    vec_ready = 1'b1;
    v_c = {24'h000000, 24'h000000, 24'h060606, 24'h050505};
    start_req(24'd5, 24'd2);
    chk("t6_addr_c1", 96'(mem_addr), 96'd5);
    tick();
    chk("t6_addr_c2", 96'(mem_addr), 96'd6);
    tick();
    $display("[TB] t6 vector data=%h mask=%h", vec_data, vec_mask);
    chk("t6_valid", 96'(vec_valid), 96'h1);
    chk("t6_data", vec_data, v_c);
    chk("t6_mask", 96'(vec_mask), 96'h3);
    tick();
    chk("t6_done", 96'(done), 96'h1);
    chk("t6_err", 96'(err), 96'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
